// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 keyboard receiver: filtered pin sampling, frame FSM, E0/F0 prefix resolution.
// Optional PS2_PAUSE_KEY_EN collapses the E1 Pause sequence into a press/release pair of E0-77 events.
module ps2_scancode_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 56000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       scan_received,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
  output logic       frame_error
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

`ifdef PS2_PAUSE_KEY_EN
  typedef enum logic [2:0] {
    P_NONE, P1, P2, P3, P4, P5, P6, P7
  } pause_state_e;

  pause_state_e pause_q, pause_d;
  logic [7:0]   pause_expect;
  pause_state_e pause_next;
`endif

  logic [1:0]            clk_sync_q, clk_sync_d;
  logic [1:0]            data_sync_q, data_sync_d;
  logic [FILTER_LEN-1:0] filt_hist_q, filt_hist_d;
  logic                  filt_clk_q, filt_clk_d;
  logic                  fall;
  logic                  data_bit;

  rx_state_e   rx_state_q, rx_state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        byte_valid_q, byte_valid_d;
  logic        rx_err;

  logic       ext_pend_q, ext_pend_d;
  logic       rel_pend_q, rel_pend_d;
  logic       scan_received_q, scan_received_d;
  logic [7:0] scancode_q, scancode_d;
  logic       extended_q, extended_d;
  logic       released_q, released_d;
  logic       frame_error_q, frame_error_d;
  logic       normal_byte;

  // Input conditioning: the clock only changes level after FILTER_LEN agreeing samples.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2clk_in};
    data_sync_d = {data_sync_q[0], ps2data_in};
    filt_hist_d = {filt_hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
    filt_clk_d  = filt_clk_q;
    if (filt_hist_q == '0) begin
      filt_clk_d = 1'b0;
    end else if (&filt_hist_q) begin
      filt_clk_d = 1'b1;
    end
    fall     = filt_clk_q & ~filt_clk_d;
    data_bit = data_sync_q[1];
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    byte_valid_d = 1'b0;
    rx_err       = 1'b0;
    to_cnt_d     = to_cnt_q + 16'd1;
    if (fall || rx_state_q == RX_IDLE) begin
      to_cnt_d = '0;
    end
    case (rx_state_q)
      RX_IDLE: begin
        if (fall && !data_bit) begin
          rx_state_d = RX_DATA;
          bitcnt_d   = '0;
          shift_d    = '0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          shift_d  = {data_bit, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            rx_state_d = RX_PARITY;
          end
        end
      end
      RX_PARITY: begin
        if (fall) begin
          parity_d   = data_bit;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          rx_state_d = RX_IDLE;
          if (data_bit && (^{shift_q, parity_q})) begin
            byte_valid_d = 1'b1;
          end else begin
            rx_err = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    // A fall in the same cycle wins over the timeout.
    if (rx_state_q != RX_IDLE && !fall && to_cnt_q == TO_LAST) begin
      rx_err     = 1'b1;
      rx_state_d = RX_IDLE;
    end
    frame_error_d = rx_err;
  end

`ifdef PS2_PAUSE_KEY_EN
  always_comb begin
    pause_expect = 8'hE1;
    pause_next   = P1;
    case (pause_q)
      P_NONE: begin pause_expect = 8'hE1; pause_next = P1;     end
      P1:     begin pause_expect = 8'h14; pause_next = P2;     end
      P2:     begin pause_expect = 8'h77; pause_next = P3;     end
      P3:     begin pause_expect = 8'hE1; pause_next = P4;     end
      P4:     begin pause_expect = 8'hF0; pause_next = P5;     end
      P5:     begin pause_expect = 8'h14; pause_next = P6;     end
      P6:     begin pause_expect = 8'hF0; pause_next = P7;     end
      P7:     begin pause_expect = 8'h77; pause_next = P_NONE; end
      default: begin pause_expect = 8'hE1; pause_next = P1;    end
    endcase
  end
`endif

  always_comb begin
    ext_pend_d      = ext_pend_q;
    rel_pend_d      = rel_pend_q;
    scan_received_d = 1'b0;
    scancode_d      = scancode_q;
    extended_d      = extended_q;
    released_d      = released_q;
    normal_byte     = byte_valid_q;
`ifdef PS2_PAUSE_KEY_EN
    pause_d = pause_q;
    if (byte_valid_q) begin
      if (shift_q == pause_expect) begin
        normal_byte = 1'b0;
        ext_pend_d  = 1'b0;
        rel_pend_d  = 1'b0;
        pause_d     = pause_next;
        if (pause_q == P2 || pause_q == P7) begin
          scan_received_d = 1'b1;
          scancode_d      = 8'h77;
          extended_d      = 1'b1;
          released_d      = (pause_q == P7);
        end
      end else if (shift_q == 8'hE1) begin
        // Broken sequence restarting on E1 begins a fresh Pause match.
        normal_byte = 1'b0;
        ext_pend_d  = 1'b0;
        rel_pend_d  = 1'b0;
        pause_d     = P1;
      end else begin
        pause_d = P_NONE;
      end
    end
`endif
    if (normal_byte) begin
      if (shift_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        rel_pend_d = 1'b1;
      end else if (!ext_pend_q && !rel_pend_q &&
                   (shift_q == 8'hAA || shift_q == 8'hFA || shift_q == 8'hEE ||
                    shift_q == 8'hFE || shift_q == 8'h00 || shift_q == 8'hFF)) begin
        ext_pend_d = 1'b0;
      end else if (ext_pend_q && (shift_q == 8'h12 || shift_q == 8'h59)) begin
        ext_pend_d = 1'b0;
        rel_pend_d = 1'b0;
      end else begin
        scan_received_d = 1'b1;
        scancode_d      = shift_q;
        extended_d      = ext_pend_q;
        released_d      = rel_pend_q;
        ext_pend_d      = 1'b0;
        rel_pend_d      = 1'b0;
      end
    end
    if (rx_err) begin
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
`ifdef PS2_PAUSE_KEY_EN
      pause_d = P_NONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q      <= 2'b11;
      data_sync_q     <= 2'b11;
      filt_hist_q     <= '1;
      filt_clk_q      <= 1'b1;
      rx_state_q      <= RX_IDLE;
      bitcnt_q        <= '0;
      shift_q         <= '0;
      parity_q        <= 1'b0;
      to_cnt_q        <= '0;
      byte_valid_q    <= 1'b0;
      ext_pend_q      <= 1'b0;
      rel_pend_q      <= 1'b0;
      scan_received_q <= 1'b0;
      scancode_q      <= '0;
      extended_q      <= 1'b0;
      released_q      <= 1'b0;
      frame_error_q   <= 1'b0;
`ifdef PS2_PAUSE_KEY_EN
      pause_q         <= P_NONE;
`endif
    end else begin
      clk_sync_q      <= clk_sync_d;
      data_sync_q     <= data_sync_d;
      filt_hist_q     <= filt_hist_d;
      filt_clk_q      <= filt_clk_d;
      rx_state_q      <= rx_state_d;
      bitcnt_q        <= bitcnt_d;
      shift_q         <= shift_d;
      parity_q        <= parity_d;
      to_cnt_q        <= to_cnt_d;
      byte_valid_q    <= byte_valid_d;
      ext_pend_q      <= ext_pend_d;
      rel_pend_q      <= rel_pend_d;
      scan_received_q <= scan_received_d;
      scancode_q      <= scancode_d;
      extended_q      <= extended_d;
      released_q      <= released_d;
      frame_error_q   <= frame_error_d;
`ifdef PS2_PAUSE_KEY_EN
      pause_q         <= pause_d;
`endif
    end
  end

  assign scan_received = scan_received_q;
  assign scancode      = scancode_q;
  assign extended      = extended_q;
  assign released      = released_q;
  assign frame_error   = frame_error_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: PS/2 frame driver, byte-level key-event model, event scoreboard.
// Model follows PS2_PAUSE_KEY_EN the same way the design does.
module tb_ps2_scancode_decoder;

  localparam int HALF    = 14;
  localparam int GAP     = 30;
  localparam int TIMEOUT = 56000;
  localparam int LATENCY = 12;

  logic       clk;
  logic       rst;
  logic       ps2clk_in;
  logic       ps2data_in;
  logic       scan_received;
  logic [7:0] scancode;
  logic       extended;
  logic       released;
  logic       frame_error;

  ps2_scancode_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .ps2clk_in     (ps2clk_in),
    .ps2data_in    (ps2data_in),
    .scan_received (scan_received),
    .scancode      (scancode),
    .extended      (extended),
    .released      (released),
    .frame_error   (frame_error)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [9:0] exp_q[$];
  logic [9:0] last_exp = '0;
  int n_checks = 0;
  int n_pass   = 0;
  int err_seen = 0;
  int err_exp  = 0;
  int stop_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: byte stream -> key events
  logic       m_ext = 1'b0;
  logic       m_rel = 1'b0;
  int         m_pidx = 0;
  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  task automatic model_byte(input logic [7:0] b);
    bit consumed;
    consumed = 1'b0;
`ifdef PS2_PAUSE_KEY_EN
    if (b == pause_seq[m_pidx]) begin
      consumed = 1'b1;
      m_pidx++;
      m_ext = 1'b0;
      m_rel = 1'b0;
      if (m_pidx == 3) exp_q.push_back({8'h77, 1'b1, 1'b0});
      if (m_pidx == 8) begin
        exp_q.push_back({8'h77, 1'b1, 1'b1});
        m_pidx = 0;
      end
    end else if (b == 8'hE1) begin
      consumed = 1'b1;
      m_pidx = 1;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else begin
      m_pidx = 0;
    end
`endif
    if (!consumed) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_rel = 1'b1;
      else if (!m_ext && !m_rel && (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
      end else if (m_ext && (b == 8'h12 || b == 8'h59)) begin
        m_ext = 1'b0;
        m_rel = 1'b0;
      end else begin
        exp_q.push_back({b, m_ext, m_rel});
        m_ext = 1'b0;
        m_rel = 1'b0;
      end
    end
  endtask

  task automatic model_clear();
    m_ext  = 1'b0;
    m_rel  = 1'b0;
    m_pidx = 0;
  endtask

  // Driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b, input logic is_stop);
    ps2data_in = b;
    wait_clks(HALF);
    ps2clk_in = 1'b0;
    if (is_stop) stop_cyc = cyc;
    wait_clks(HALF);
    ps2clk_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    if (bad_par || bad_stop) begin
      err_exp++;
      model_clear();
    end else begin
      model_byte(b);
    end
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(~bad_stop, 1'b1);
    ps2data_in = 1'b1;
    wait_clks(GAP);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic send_partial(input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
    ps2data_in = 1'b1;
  endtask

  // Monitor: pops the expected queue on every strobe
  always @(negedge clk) begin
    if (!rst && scan_received) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {22'b0, scancode, extended, released}, 32'h3ff_ffff);
      end else begin
        last_exp = exp_q.pop_front();
        check("event", {22'b0, scancode, extended, released}, {22'b0, last_exp});
        check("latency", 32'(cyc - stop_cyc), LATENCY);
      end
    end
    if (!rst && frame_error) err_seen++;
  end

  initial begin
    logic [7:0] disc [6];
    logic [7:0] b;
    int r;
    disc = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    rst = 1'b1;
    ps2clk_in = 1'b1;
    ps2data_in = 1'b1;
    wait_clks(4);
    check("rst_scan_received", {31'b0, scan_received}, 0);
    check("rst_scancode", {24'b0, scancode}, 0);
    check("rst_extended", {31'b0, extended}, 0);
    check("rst_released", {31'b0, released}, 0);
    check("rst_frame_error", {31'b0, frame_error}, 0);
    rst = 1'b0;
    wait_clks(20);

    // Plain make, release and extended release
    send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("no_error_clean", 32'(err_seen), 32'(err_exp));

    // Parity and stop errors drop the byte and the pending prefix
    send_byte(8'hE0);
    send_frame(8'h1C, 1'b1, 1'b0);
    check("parity_error", 32'(err_seen), 32'(err_exp));
    send_byte(8'h32);
    send_byte(8'hF0);
    send_frame(8'h44, 1'b0, 1'b1);
    check("stop_error", 32'(err_seen), 32'(err_exp));
    send_byte(8'h32);

    // Timeout mid-frame, prefix pending beforehand
    send_byte(8'hE0);
    err_exp++;
    model_clear();
    send_partial(4);
    wait_clks(TIMEOUT + 100);
    check("timeout_error", 32'(err_seen), 32'(err_exp));
    send_byte(8'h29);

    // Reset in the middle of a frame
    send_byte(8'hE0);
    send_partial(5);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    model_clear();
    wait_clks(1);
    check("midrst_scancode", {24'b0, scancode}, 0);
    check("midrst_scan_received", {31'b0, scan_received}, 0);
    wait_clks(20);
    send_byte(8'h29);

    // Discards and fake shifts
    send_byte(8'hAA);
    send_byte(8'hE0); send_byte(8'h12);
    send_byte(8'hE0); send_byte(8'h7C);

    // Short clock glitches while data is low must not start a frame
    ps2data_in = 1'b0;
    for (int g = 0; g < 3; g++) begin
      ps2clk_in = 1'b0;
      wait_clks(2);
      ps2clk_in = 1'b1;
      wait_clks(20);
    end
    ps2data_in = 1'b1;
    wait_clks(20);
    send_byte(8'h1C);
    check("glitch_no_error", 32'(err_seen), 32'(err_exp));

    // Pause key sequence
    for (int k = 0; k < 8; k++) send_byte(pause_seq[k]);
    send_byte(8'h83);

    // Randomised byte stream
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = disc[$urandom_range(0, 5)];
        3: b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        4: b = 8'hE1;
        default: b = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 11) == 0) send_frame(b, 1'b1, 1'b0);
      else send_byte(b);
    end
    send_byte(8'h5A);
    wait_clks(40);

    check("final_errors", 32'(err_seen), 32'(err_exp));
    check("events_drained", 32'(exp_q.size()), 0);
    check("outputs_hold", {22'b0, scancode, extended, released}, {22'b0, last_exp});
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
